mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single 256-bit line-fill memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs). It sits between the two caches and the memory/MMU side. It serialises their requests into one outstanding transaction at a time, steers the returned line, ack and hardware page-fault back to the owner, and registers all memory-side request signals.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one line-fill memory port between icache and dcache, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed dcache priority.
//
// state | meaning
// IDLE  | no transaction outstanding
// GNT_I | icache owns the memory port
// GNT_D | dcache owns the memory port
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    input  logic                  ic_rd_i,
    output logic [LINE_BITS-1:0]  ic_data_o,
    output logic                  ic_ack_o,
    output logic                  ic_page_fault_o,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic                  dc_rd_i,
    input  logic                  dc_wr_i,
    input  logic [LINE_BITS-1:0]  dc_data_i,
    output logic [LINE_BITS-1:0]  dc_data_o,
    output logic                  dc_ack_o,
    output logic                  dc_page_fault_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_BITS-1:0]  mem_data_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    input  logic [LINE_BITS-1:0]  mem_data_i,
    input  logic                  mem_ack_i,
    input  logic                  mem_page_fault_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [LINE_BITS-1:0]  data_nxt;
    logic                  rd_nxt, wr_nxt;
    logic                  pend_i, pend_d, pick_d;

    assign pend_i = ic_rd_i;
    assign pend_d = dc_rd_i | dc_wr_i;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not win last time goes first.
    assign pick_d = pend_d & (~pend_i | ~last_grant);
`else
    assign pick_d = pend_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            mem_addr_o <= addr_nxt;
            mem_data_o <= data_nxt;
            mem_rd_o   <= rd_nxt;
            mem_wr_o   <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        addr_nxt       = mem_addr_o;
        data_nxt       = mem_data_o;
        rd_nxt         = mem_rd_o;
        wr_nxt         = mem_wr_o;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt      = GNT_D;
                    last_grant_nxt = 1'b1;
                    addr_nxt       = dc_addr_i;
                    // A write-back takes precedence over a simultaneous fill.
                    rd_nxt         = ~dc_wr_i;
                    wr_nxt         = dc_wr_i;
                    if (dc_wr_i) data_nxt = dc_data_i;
                end else if (pend_i) begin
                    state_nxt      = GNT_I;
                    last_grant_nxt = 1'b0;
                    addr_nxt       = ic_addr_i;
                    rd_nxt         = 1'b1;
                    wr_nxt         = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ic_data_o       = mem_data_i;
    assign dc_data_o       = mem_data_i;
    assign ic_ack_o        = mem_ack_i & (state == GNT_I);
    assign dc_ack_o        = mem_ack_i & (state == GNT_D);
    assign ic_page_fault_o = mem_page_fault_i & ic_ack_o;
    assign dc_page_fault_o = mem_page_fault_i & dc_ack_o;
    assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LB = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ic_addr_i = '0;
    logic          ic_rd_i = 1'b0;
    logic [LB-1:0] ic_data_o;
    logic          ic_ack_o, ic_page_fault_o;
    logic [AW-1:0] dc_addr_i = '0;
    logic          dc_rd_i = 1'b0, dc_wr_i = 1'b0;
    logic [LB-1:0] dc_data_i = '0;
    logic [LB-1:0] dc_data_o;
    logic          dc_ack_o, dc_page_fault_o;
    logic [AW-1:0] mem_addr_o;
    logic [LB-1:0] mem_data_o;
    logic          mem_rd_o, mem_wr_o;
    logic [LB-1:0] mem_data_i = '0;
    logic          mem_ack_i = 1'b0, mem_page_fault_i = 1'b0;
    logic          busy_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .ic_addr_i(ic_addr_i), .ic_rd_i(ic_rd_i), .ic_data_o(ic_data_o),
        .ic_ack_o(ic_ack_o), .ic_page_fault_o(ic_page_fault_o),
        .dc_addr_i(dc_addr_i), .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i),
        .dc_data_i(dc_data_i), .dc_data_o(dc_data_o), .dc_ack_o(dc_ack_o),
        .dc_page_fault_o(dc_page_fault_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_page_fault_i(mem_page_fault_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else pass_cnt++;
        chk_cnt++; if ({mem_rd_o, mem_wr_o} !== 2'b00) $display("FAIL reset_rd_wr got %b want 00", {mem_rd_o, mem_wr_o}); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== '0) $display("FAIL reset_addr got %h want 0", mem_addr_o); else pass_cnt++;
        chk_cnt++; if (mem_data_o !== '0) $display("FAIL reset_data got %h want 0", mem_data_o); else pass_cnt++;
        chk_cnt++; if ({ic_ack_o, dc_ack_o} !== 2'b00) $display("FAIL reset_acks got %b want 00", {ic_ack_o, dc_ack_o}); else pass_cnt++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_ic_fill;
        logic [LB-1:0] line;
        line = {8{32'h1234_5678}};
        ic_addr_i = 32'h0000_1040;
        ic_rd_i   = 1'b1;
        step();
        chk_cnt++; if (mem_rd_o !== 1'b1) $display("FAIL ic_rd got %b want 1", mem_rd_o); else pass_cnt++;
        chk_cnt++; if (mem_wr_o !== 1'b0) $display("FAIL ic_wr got %b want 0", mem_wr_o); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== 32'h0000_1040) $display("FAIL ic_addr got %h want 00001040", mem_addr_o); else pass_cnt++;
        chk_cnt++; if (busy_o !== 1'b1) $display("FAIL ic_busy got %b want 1", busy_o); else pass_cnt++;
        step();
        step();
        chk_cnt++; if ({mem_rd_o, ic_ack_o} !== 2'b10) $display("FAIL ic_hold got rd/ack %b want 10", {mem_rd_o, ic_ack_o}); else pass_cnt++;
        mem_ack_i  = 1'b1;
        mem_data_i = line;
        #1;
        chk_cnt++; if (ic_ack_o !== 1'b1) $display("FAIL ic_ack got %b want 1", ic_ack_o); else pass_cnt++;
        chk_cnt++; if (ic_data_o !== line) $display("FAIL ic_data got %h want %h", ic_data_o, line); else pass_cnt++;
        chk_cnt++; if (dc_ack_o !== 1'b0) $display("FAIL ic_dc_ack got %b want 0", dc_ack_o); else pass_cnt++;
        chk_cnt++; if (ic_page_fault_o !== 1'b0) $display("FAIL ic_pf got %b want 0", ic_page_fault_o); else pass_cnt++;
        step();
        mem_ack_i = 1'b0;
        ic_rd_i   = 1'b0;
        #1;
        chk_cnt++; if (ic_ack_o !== 1'b0) $display("FAIL ic_ack_pulse got %b want 0", ic_ack_o); else pass_cnt++;
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL ic_busy_after got %b want 0", busy_o); else pass_cnt++;
        chk_cnt++; if ({mem_rd_o, mem_addr_o} !== {1'b0, 32'h0}) $display("FAIL ic_clear got rd %b addr %h want 0 0", mem_rd_o, mem_addr_o); else pass_cnt++;
        step();
    endtask

    task automatic test_dc_writeback;
        logic [LB-1:0] pat;
        pat = {32{8'hA5}};
        dc_addr_i = 32'h0000_2000;
        dc_data_i = pat;
        dc_wr_i   = 1'b1;
        dc_rd_i   = 1'b1;
        step();
        chk_cnt++; if ({mem_wr_o, mem_rd_o} !== 2'b10) $display("FAIL wb_wr_rd got %b want 10", {mem_wr_o, mem_rd_o}); else pass_cnt++;
        chk_cnt++; if (mem_data_o !== pat) $display("FAIL wb_data got %h want %h", mem_data_o, pat); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== 32'h0000_2000) $display("FAIL wb_addr got %h want 00002000", mem_addr_o); else pass_cnt++;
        dc_data_i = '0;
        step();
        chk_cnt++; if (mem_data_o !== pat) $display("FAIL wb_data_hold got %h want %h", mem_data_o, pat); else pass_cnt++;
        mem_ack_i = 1'b1;
        #1;
        chk_cnt++; if ({dc_ack_o, ic_ack_o} !== 2'b10) $display("FAIL wb_ack got dc/ic %b want 10", {dc_ack_o, ic_ack_o}); else pass_cnt++;
        step();
        mem_ack_i = 1'b0;
        dc_wr_i   = 1'b0;
        dc_rd_i   = 1'b0;
        #1;
        chk_cnt++; if (dc_ack_o !== 1'b0) $display("FAIL wb_ack_pulse got %b want 0", dc_ack_o); else pass_cnt++;
        chk_cnt++; if ({mem_wr_o, busy_o} !== 2'b00) $display("FAIL wb_clear got wr/busy %b want 00", {mem_wr_o, busy_o}); else pass_cnt++;
        chk_cnt++; if (mem_data_o !== pat) $display("FAIL wb_data_kept got %h want %h", mem_data_o, pat); else pass_cnt++;
        step();
    endtask

    task automatic test_arbitration;
        logic          exp_d [4];
        logic [AW-1:0] exp_addr;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        ic_addr_i = 32'h0000_0100;
        dc_addr_i = 32'h0000_0200;
        ic_rd_i   = 1'b1;
        dc_rd_i   = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_addr = exp_d[g] ? 32'h0000_0200 : 32'h0000_0100;
            step();
            chk_cnt++; if ({mem_rd_o, mem_addr_o} !== {1'b1, exp_addr})
                $display("FAIL arb_grant%0d got rd %b addr %h want 1 %h", g, mem_rd_o, mem_addr_o, exp_addr); else pass_cnt++;
            mem_ack_i = 1'b1;
            #1;
            chk_cnt++; if ({dc_ack_o, ic_ack_o} !== {exp_d[g], ~exp_d[g]})
                $display("FAIL arb_ack%0d got dc/ic %b want %b", g, {dc_ack_o, ic_ack_o}, {exp_d[g], ~exp_d[g]}); else pass_cnt++;
            step();
            mem_ack_i = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
            dc_rd_i = ~exp_d[g];
`endif
            chk_cnt++; if (busy_o !== 1'b0) $display("FAIL arb_turn%0d busy got %b want 0", g, busy_o); else pass_cnt++;
        end
        ic_rd_i = 1'b0;
        dc_rd_i = 1'b0;
        step();
    endtask

    task automatic test_page_fault;
        ic_addr_i = 32'h0000_3000;
        ic_rd_i   = 1'b1;
        step();
        mem_ack_i        = 1'b1;
        mem_page_fault_i = 1'b1;
        #1;
        chk_cnt++; if ({ic_ack_o, ic_page_fault_o} !== 2'b11) $display("FAIL pf_ic got ack/pf %b want 11", {ic_ack_o, ic_page_fault_o}); else pass_cnt++;
        chk_cnt++; if (dc_page_fault_o !== 1'b0) $display("FAIL pf_dc got %b want 0", dc_page_fault_o); else pass_cnt++;
        step();
        mem_ack_i        = 1'b0;
        mem_page_fault_i = 1'b0;
        ic_rd_i          = 1'b0;
        step();
    endtask

    task automatic test_spurious_and_reset;
        mem_ack_i        = 1'b1;
        mem_page_fault_i = 1'b1;
        #1;
        chk_cnt++; if ({ic_ack_o, dc_ack_o, ic_page_fault_o, dc_page_fault_o} !== 4'b0000)
            $display("FAIL spur_outs got %b want 0000", {ic_ack_o, dc_ack_o, ic_page_fault_o, dc_page_fault_o}); else pass_cnt++;
        step();
        mem_ack_i        = 1'b0;
        mem_page_fault_i = 1'b0;
        chk_cnt++; if ({busy_o, mem_rd_o, mem_wr_o} !== 3'b000) $display("FAIL spur_state got %b want 000", {busy_o, mem_rd_o, mem_wr_o}); else pass_cnt++;
        dc_addr_i = 32'h0000_4000;
        dc_rd_i   = 1'b1;
        step();
        chk_cnt++; if ({busy_o, mem_rd_o} !== 2'b11) $display("FAIL rst_pre got busy/rd %b want 11", {busy_o, mem_rd_o}); else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        chk_cnt++; if ({mem_rd_o, mem_wr_o, busy_o} !== 3'b000) $display("FAIL rst_async got rd/wr/busy %b want 000", {mem_rd_o, mem_wr_o, busy_o}); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== '0) $display("FAIL rst_addr got %h want 0", mem_addr_o); else pass_cnt++;
        dc_rd_i = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_ic_fill();
        test_dc_writeback();
        test_arbitration();
        test_page_fault();
        test_spurious_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
